// File: rtl/parking_time_log_if.sv
// Request/response bundle for the parking time logger.
// Master issues entry/exit requests with the timer; slave reports slot state.
interface parking_time_log_if #(
    parameter int TW    = 11,
    parameter int SLOTS = 4,
    parameter int SW    = $clog2(SLOTS)
);
    logic [TW-1:0]    timer;
    logic             entry_valid;
    logic [SW-1:0]    entry_slot;
    logic             exit_valid;
    logic [SW-1:0]    exit_slot;
    logic [SLOTS-1:0] occupied;
    logic [SW:0]      occ_count;
    logic             full;
    logic [TW-1:0]    duration;
    logic             duration_valid;
    logic             err_entry;
    logic             err_exit;

    modport master (
        output timer, entry_valid, entry_slot, exit_valid, exit_slot,
        input  occupied, occ_count, full, duration, duration_valid,
        input  err_entry, err_exit
    );

    modport slave (
        input  timer, entry_valid, entry_slot, exit_valid, exit_slot,
        output occupied, occ_count, full, duration, duration_valid,
        output err_entry, err_exit
    );
endinterface

// File: rtl/parking_time_log.sv
// Per-slot entry timestamp log; reports elapsed time on exit.
// All outputs registered, one cycle after the request edge.
module parking_time_log #(
    parameter int TW    = 11,
    parameter int SLOTS = 4,
    parameter int SW    = $clog2(SLOTS)
) (
    input  logic                clk,
    input  logic                reset,
    parking_time_log_if.slave   bus
);
    logic [SLOTS-1:0] occupied_q, occupied_d;
    logic [TW-1:0]    stamp_q [SLOTS];
    logic [TW-1:0]    stamp_d [SLOTS];
    logic [SW:0]      occ_count_q, occ_count_d;
    logic             full_q, full_d;
    logic [TW-1:0]    duration_q, duration_d;
    logic             duration_valid_q, duration_valid_d;
    logic             err_entry_q, err_entry_d;
    logic             err_exit_q, err_exit_d;

    logic entry_in, exit_in, entry_ok, exit_ok;

    assign entry_in = bus.entry_valid &&
                      ({1'b0, bus.entry_slot} < (SW+1)'(SLOTS));
    assign exit_in  = bus.exit_valid &&
                      ({1'b0, bus.exit_slot} < (SW+1)'(SLOTS));

    // Exit is evaluated first so a same-slot entry can re-arm a BUSY slot.
    assign exit_ok  = exit_in && occupied_q[bus.exit_slot];
    assign entry_ok = entry_in &&
                      (!occupied_q[bus.entry_slot] ||
                       (exit_ok && bus.exit_slot == bus.entry_slot));

    always_comb begin
        occupied_d       = occupied_q;
        stamp_d          = stamp_q;
        duration_d       = duration_q;
        duration_valid_d = exit_ok;
        err_entry_d      = bus.entry_valid && !entry_ok;
        err_exit_d       = bus.exit_valid && !exit_ok;
        occ_count_d      = '0;
        if (exit_ok) begin
            occupied_d[bus.exit_slot] = 1'b0;
            duration_d = bus.timer - stamp_q[bus.exit_slot];
        end
        if (entry_ok) begin
            occupied_d[bus.entry_slot] = 1'b1;
            stamp_d[bus.entry_slot]    = bus.timer;
        end
        for (int i = 0; i < SLOTS; i++)
            occ_count_d = occ_count_d + (SW+1)'(occupied_d[i]);
        full_d = (occ_count_d == (SW+1)'(SLOTS));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            occupied_q       <= '0;
            stamp_q          <= '{default: '0};
            occ_count_q      <= '0;
            full_q           <= 1'b0;
            duration_q       <= '0;
            duration_valid_q <= 1'b0;
            err_entry_q      <= 1'b0;
            err_exit_q       <= 1'b0;
        end else begin
            occupied_q       <= occupied_d;
            stamp_q          <= stamp_d;
            occ_count_q      <= occ_count_d;
            full_q           <= full_d;
            duration_q       <= duration_d;
            duration_valid_q <= duration_valid_d;
            err_entry_q      <= err_entry_d;
            err_exit_q       <= err_exit_d;
        end
    end

    assign bus.occupied       = occupied_q;
    assign bus.occ_count      = occ_count_q;
    assign bus.full           = full_q;
    assign bus.duration       = duration_q;
    assign bus.duration_valid = duration_valid_q;
    assign bus.err_entry      = err_entry_q;
    assign bus.err_exit       = err_exit_q;
endmodule

// File: tb/tb_parking_time_log.sv
// Directed vector table, reset corner cases and randomized
// traffic checked against a sequential exit-then-entry model.
module tb_parking_time_log;
    localparam int TW    = 11;
    localparam int SLOTS = 4;
    localparam int SW    = 2;
    localparam int OW    = SLOTS + SW + 1 + 1 + TW + 3;

    typedef struct {
        logic          rst_n;
        logic          ev;
        logic [SW-1:0] es;
        logic          xv;
        logic [SW-1:0] xs;
        logic [TW-1:0] t;
        logic [OW-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    parking_time_log_if #(.TW(TW), .SLOTS(SLOTS), .SW(SW)) bus ();

    parking_time_log #(.TW(TW), .SLOTS(SLOTS), .SW(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] pack(
        input logic [SLOTS-1:0] occ, input logic [SW:0] cnt,
        input logic full, input logic [TW-1:0] dur,
        input logic dv, input logic ee, input logic xe);
        return {occ, cnt, full, dur, dv, ee, xe};
    endfunction

    function automatic logic [OW-1:0] got();
        return pack(bus.occupied, bus.occ_count, bus.full, bus.duration,
                    bus.duration_valid, bus.err_entry, bus.err_exit);
    endfunction

    task automatic check(input string name, input logic [OW-1:0] exp);
        logic [OW-1:0] g;
        g = got();
        n_tests++;
        if (g !== exp) begin
            n_fail++;
            $display("FAIL %s got occ/cnt/full/dur/dv/ee/xe=%h/%0d/%b/%0d/%b/%b/%b want %h/%0d/%b/%0d/%b/%b/%b",
                name, g[OW-1 -: SLOTS], g[OW-SLOTS-1 -: SW+1],
                g[TW+3], g[TW+2:3], g[2], g[1], g[0],
                exp[OW-1 -: SLOTS], exp[OW-SLOTS-1 -: SW+1],
                exp[TW+3], exp[TW+2:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input logic r, input logic ev, input logic [SW-1:0] es,
                         input logic xv, input logic [SW-1:0] xs,
                         input logic [TW-1:0] t);
        reset           = r;
        bus.entry_valid = ev;
        bus.entry_slot  = es;
        bus.exit_valid  = xv;
        bus.exit_slot   = xs;
        bus.timer       = t;
    endtask

    task automatic add(input logic r, input logic ev, input int es,
                       input logic xv, input int xs, input int t,
                       input logic [SLOTS-1:0] occ, input int cnt,
                       input logic full, input int dur,
                       input logic dv, input logic ee, input logic xe);
        vec_t v;
        v.rst_n = r; v.ev = ev; v.es = SW'(es);
        v.xv = xv; v.xs = SW'(xs); v.t = TW'(t);
        v.exp = pack(occ, (SW+1)'(cnt), full, TW'(dur), dv, ee, xe);
        vecs.push_back(v);
    endtask

    // Reference state for random traffic
    bit      m_busy [SLOTS];
    int      m_stamp[SLOTS];
    int      m_dur;

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++) begin
            m_busy[i] = 0;
            m_stamp[i] = 0;
        end
        m_dur = 0;
    endtask

    initial begin
        logic [SLOTS-1:0] occ;
        int t, es, xs, cnt;
        bit ev, xv, r, dv, ee, xe;

        drive(1'b0, 0, 0, 0, 0, 0);

        //  rst ev es xv xs  t     occ   cnt f dur dv ee xe
        add(0, 0, 0, 0, 0,    0, 4'b0000, 0, 0,   0, 0, 0, 0);
        add(1, 1, 2, 0, 0,  100, 4'b0100, 1, 0,   0, 0, 0, 0);
        add(1, 0, 0, 0, 0,  110, 4'b0100, 1, 0,   0, 0, 0, 0);
        add(1, 0, 0, 1, 2,  130, 4'b0000, 0, 0,  30, 1, 0, 0);
        add(1, 0, 0, 0, 0,  140, 4'b0000, 0, 0,  30, 0, 0, 0);
        add(1, 1, 1, 0, 0, 2040, 4'b0010, 1, 0,  30, 0, 0, 0);
        add(1, 0, 0, 1, 1,   10, 4'b0000, 0, 0,  18, 1, 0, 0);
        add(1, 1, 0, 0, 0,  200, 4'b0001, 1, 0,  18, 0, 0, 0);
        add(1, 1, 1, 0, 0,  201, 4'b0011, 2, 0,  18, 0, 0, 0);
        add(1, 1, 2, 0, 0,  202, 4'b0111, 3, 0,  18, 0, 0, 0);
        add(1, 1, 3, 0, 0,  203, 4'b1111, 4, 1,  18, 0, 0, 0);
        add(1, 1, 0, 0, 0,  300, 4'b1111, 4, 1,  18, 0, 1, 0);
        add(1, 0, 0, 1, 0,  250, 4'b1110, 3, 0,  50, 1, 0, 0);
        add(1, 0, 0, 1, 3,  263, 4'b0110, 2, 0,  60, 1, 0, 0);
        add(1, 0, 0, 1, 3,  270, 4'b0110, 2, 0,  60, 0, 0, 1);
        add(1, 1, 0, 0, 0,   50, 4'b0111, 3, 0,  60, 0, 0, 0);
        add(1, 1, 0, 1, 0,   80, 4'b0111, 3, 0,  30, 1, 0, 0);
        add(1, 0, 0, 1, 0,   90, 4'b0110, 2, 0,  10, 1, 0, 0);
        add(1, 1, 0, 1, 0,   95, 4'b0111, 3, 0,  10, 0, 0, 1);
        add(1, 1, 3, 1, 1,  400, 4'b1101, 3, 0, 199, 1, 0, 0);
        add(0, 0, 0, 1, 0,  410, 4'b0000, 0, 0,   0, 0, 0, 0);
        add(1, 0, 0, 0, 0,  420, 4'b0000, 0, 0,   0, 0, 0, 0);

        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].ev, vecs[i].es,
                  vecs[i].xv, vecs[i].xs, vecs[i].t);
            @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset falling mid-cycle must not disturb outputs before the edge
        drive(1'b1, 1, 0, 0, 0, 11'd5);
        @(negedge clk);
        check("pre_async", pack(4'b0001, 1, 0, 0, 0, 0, 0));
        drive(1'b0, 0, 0, 0, 0, 11'd6);
        #2;
        check("no_async_rst", pack(4'b0001, 1, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("sync_rst", pack(4'b0000, 0, 0, 0, 0, 0, 0));

        // Randomized traffic
        model_reset();
        t = 0;
        for (int c = 0; c < 400; c++) begin
            r  = ($urandom_range(0, 39) != 0);
            ev = $urandom_range(0, 1);
            xv = $urandom_range(0, 1);
            es = $urandom_range(0, SLOTS - 1);
            xs = $urandom_range(0, SLOTS - 1);
            t  = (t + $urandom_range(0, 40)) % (1 << TW);
            drive(r, ev, SW'(es), xv, SW'(xs), TW'(t));
            dv = 0; ee = 0; xe = 0;
            if (!r) begin
                model_reset();
            end else begin
                if (xv) begin
                    if (m_busy[xs]) begin
                        m_dur = (t - m_stamp[xs] + (1 << TW)) % (1 << TW);
                        m_busy[xs] = 0;
                        dv = 1;
                    end else begin
                        xe = 1;
                    end
                end
                if (ev) begin
                    if (!m_busy[es]) begin
                        m_busy[es] = 1;
                        m_stamp[es] = t;
                    end else begin
                        ee = 1;
                    end
                end
            end
            cnt = 0;
            for (int i = 0; i < SLOTS; i++) begin
                occ[i] = m_busy[i];
                cnt += m_busy[i];
            end
            @(negedge clk);
            check($sformatf("rand%0d", c),
                  pack(occ, (SW+1)'(cnt), cnt == SLOTS, TW'(m_dur), dv, ee, xe));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/parking_time_log.md
PARKING_TIME_LOG -- requirements
Module: parking_time_log

Interface
REQ-001 Parameter TW, default 11, timer/timestamp width in bits.
REQ-002 Parameter SLOTS, default 4, number of independent parking-slot channels (legal range 2..64).
REQ-003 Parameter SW, default $clog2(SLOTS), slot index width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-006 timer  input  TW  free-running time count from the system timer, treated as unsigned modulo 2^TW.
REQ-007 entry_valid  input  1  one-cycle request to log an entry timestamp.
REQ-008 entry_slot  input  SW  slot index for the entry request.
REQ-009 exit_valid  input  1  one-cycle request to close a slot and report its duration.
REQ-010 exit_slot  input  SW  slot index for the exit request.
REQ-011 occupied  output  SLOTS  per-slot occupied flag, registered.
REQ-012 occ_count  output  SW+1  number of set bits in occupied, registered.
REQ-013 full  output  1  high when occ_count == SLOTS, registered.
REQ-014 duration  output  TW  elapsed time of the last accepted exit, registered.
REQ-015 duration_valid  output  1  one-cycle pulse qualifying duration.
REQ-016 err_entry  output  1  one-cycle pulse: entry rejected.
REQ-017 err_exit  output  1  one-cycle pulse: exit rejected.

Function
REQ-018 Per slot, the block SHALL hold a TW-bit stamp register and an occupied bit; two states per slot: FREE (occupied=0), BUSY (occupied=1).
REQ-019 Entry accepted (entry_valid=1, entry_slot<SLOTS, slot FREE): stamp <= timer, slot -> BUSY at the same edge.
REQ-020 Entry rejected (slot BUSY or entry_slot>=SLOTS): no state change; err_entry=1 in the following cycle.
REQ-021 Exit accepted (exit_valid=1, exit_slot<SLOTS, slot BUSY): duration <= (timer - stamp) mod 2^TW, duration_valid=1 in the following cycle, slot -> FREE.
REQ-022 Exit rejected (slot FREE or exit_slot>=SLOTS): duration unchanged; duration_valid=0; err_exit=1 in the following cycle.
REQ-023 Latency: every output SHALL reflect a request exactly one clock after the edge at which the request is sampled.
REQ-024 Timer wrap: when timer has wrapped since entry, duration is the modulo-2^TW difference; one wrap maximum is representable, which the system guarantees.
REQ-025 Same-cycle entry and exit to different slots: both SHALL be processed independently.
REQ-026 Same-cycle entry and exit to the same BUSY slot: exit processed with the old stamp, then entry re-arms; slot stays BUSY with stamp = current timer; no error pulse.
REQ-027 Same-cycle entry and exit to the same FREE slot: entry accepted; exit rejected (err_exit=1); slot ends BUSY.
REQ-028 occ_count and full SHALL be consistent with occupied in the same cycle (all derived from next-state values).
REQ-029 duration_valid, err_entry and err_exit SHALL be low in every cycle not caused by a request in the previous cycle.

Reset
REQ-030 With reset=0 at a clock edge: occupied=0, occ_count=0, full=0, duration=0, duration_valid=0, err_entry=0, err_exit=0; stamps cleared to 0.
REQ-031 Reset SHALL override any same-cycle entry or exit request; requests in flight are discarded without error pulses.
REQ-032 Outputs SHALL NOT change asynchronously when reset falls between edges.

Verification
REQ-033 Reset, timer=100, entry slot 2; timer=130, exit slot 2 -> next cycle duration=30, duration_valid=1, occupied[2]=0.
REQ-034 Entry slot 1 at timer=2040; exit slot 1 at timer=10 (TW=11) -> duration=18.
REQ-035 Entries to slots 0..3 -> full=1, occ_count=4; fifth entry to slot 0 -> err_entry=1, stamp of slot 0 unchanged.
REQ-036 Exit on FREE slot 3 -> err_exit=1, duration_valid=0, duration unchanged.
REQ-037 Slot 0 BUSY stamp=50; same cycle entry+exit slot 0 at timer=80 -> duration=30, duration_valid=1, occupied[0]=1, later exit at timer=90 gives duration=10.
REQ-038 Slots 0,1 BUSY; reset=0 coincident with exit slot 0 -> next cycle all outputs zero, no duration_valid, no err pulses.
